// File: rtl/mem_arb_pkg.sv
// Shared op and arbiter state encodings.
// Used by mem_arbiter_rr, mem_ctrl and the masters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner search over a request vector.
// Ports: req, ptr, mode (1 = fixed) in; winner, found out.
module arb_picker #(
  parameter int NUM_SRC = 4,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               mode,
  output logic [IW-1:0]      winner,
  output logic               found
);

  logic [IW-1:0] base;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  assign base = mode ? '0 : ptr;

  // Walk from base upward, wrapping at NUM_SRC;
  // first requester seen wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, base} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_SRC))
        sum = sum - (IW+1)'(NUM_SRC);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-source memory arbiter onto the single mem_ctrl port.
// Ports: per-source op/addr/offset/wdata in, responses out; mem_ctrl side.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 512,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0][1:0]             op_src,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  raw_address_src,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  address_offset_src,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  wr_data_src,
  output logic [DATA_WIDTH-1:0]               rd_data_src,
  output logic [NUM_SRC-1:0]                  tx_done_src,
  output logic [NUM_SRC-1:0]                  rd_valid_src,
  output logic [1:0]                          op,
  output logic [ADDR_WIDTH-1:0]               raw_address,
  output logic [DATA_WIDTH-1:0]               wr_data,
  input  logic [DATA_WIDTH-1:0]               rd_data,
  input  logic                                tx_done,
  input  logic                                rd_valid,
  output logic                                busy,
  output logic [$clog2(NUM_SRC)-1:0]          grant_id,
  output logic                                proto_err
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic FIXED = (PRIORITY_MODE != 0);

  arb_state_t state, state_n;
  op_t op_q, op_n;

  logic [NUM_SRC-1:0]    req, illegal;
  logic [IW-1:0]         ptr, ptr_n, winner;
  logic                  found;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, rdata_n;
  logic [NUM_SRC-1:0]    done_n, rvld_n;
  logic                  busy_n, perr_n;
  logic [IW-1:0]         gid_n;

  always_comb begin
    req     = '0;
    illegal = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i]     = (op_src[i] == OP_READ) ||
                   (op_src[i] == OP_WRITE);
      illegal[i] = (op_src[i] == OP_ILLEGAL);
    end
  end

  arb_picker #(
    .NUM_SRC(NUM_SRC),
    .IW     (IW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .mode  (FIXED),
    .winner(winner),
    .found (found)
  );

  always_comb begin
    state_n = state;
    op_n    = op_q;
    addr_n  = raw_address;
    wdata_n = wr_data;
    rdata_n = rd_data_src;
    gid_n   = grant_id;
    ptr_n   = ptr;
    busy_n  = busy;
    done_n  = '0;
    rvld_n  = '0;
    perr_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        perr_n = |illegal;
        if (found) begin
          op_n    = op_t'(op_src[winner]);
          addr_n  = raw_address_src[winner] +
                    address_offset_src[winner];
          wdata_n = wr_data_src[winner];
          gid_n   = winner;
          busy_n  = 1'b1;
          state_n = ST_BUSY;
          if (!FIXED)
            ptr_n = (winner == IW'(NUM_SRC-1)) ?
                    '0 : winner + 1'b1;
        end
      end
      ST_BUSY: begin
        if (rd_valid) begin
          rdata_n          = rd_data;
          rvld_n[grant_id] = 1'b1;
        end
        // Completion pulse is registered here so it is
        // visible during RESP, while requests are masked.
        if (tx_done) begin
          op_n             = OP_IDLE;
          busy_n           = 1'b0;
          done_n[grant_id] = 1'b1;
          state_n          = ST_RESP;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_IDLE;
      raw_address  <= '0;
      wr_data      <= '0;
      rd_data_src  <= '0;
      tx_done_src  <= '0;
      rd_valid_src <= '0;
      busy         <= 1'b0;
      grant_id     <= '0;
      proto_err    <= 1'b0;
      ptr          <= '0;
    end else begin
      state        <= state_n;
      op_q         <= op_n;
      raw_address  <= addr_n;
      wr_data      <= wdata_n;
      rd_data_src  <= rdata_n;
      tx_done_src  <= done_n;
      rd_valid_src <= rvld_n;
      busy         <= busy_n;
      grant_id     <= gid_n;
      proto_err    <= perr_n;
      ptr          <= ptr_n;
    end
  end

  assign op = op_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr.
// Instance u_rr is round robin, u_fx is fixed priority; inputs shared.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0][1:0]    op_src;
  logic [N-1:0][AW-1:0] raw_address_src;
  logic [N-1:0][AW-1:0] address_offset_src;
  logic [N-1:0][DW-1:0] wr_data_src;
  logic [DW-1:0]        rd_data;
  logic                 tx_done;
  logic                 rd_valid;

  logic [DW-1:0] rd_data_src, f_rd_data_src;
  logic [N-1:0]  tx_done_src, f_tx_done_src;
  logic [N-1:0]  rd_valid_src, f_rd_valid_src;
  logic [1:0]    op, f_op;
  logic [AW-1:0] raw_address, f_raw_address;
  logic [DW-1:0] wr_data, f_wr_data;
  logic          busy, f_busy;
  logic [1:0]    grant_id, f_grant_id;
  logic          proto_err, f_proto_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .NUM_SRC(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .PRIORITY_MODE(0)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .op_src(op_src),
    .raw_address_src(raw_address_src),
    .address_offset_src(address_offset_src),
    .wr_data_src(wr_data_src),
    .rd_data_src(rd_data_src),
    .tx_done_src(tx_done_src),
    .rd_valid_src(rd_valid_src),
    .op(op), .raw_address(raw_address),
    .wr_data(wr_data), .rd_data(rd_data),
    .tx_done(tx_done), .rd_valid(rd_valid),
    .busy(busy), .grant_id(grant_id),
    .proto_err(proto_err)
  );

  mem_arbiter_rr #(
    .NUM_SRC(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .PRIORITY_MODE(1)
  ) u_fx (
    .clk(clk), .rst_n(rst_n),
    .op_src(op_src),
    .raw_address_src(raw_address_src),
    .address_offset_src(address_offset_src),
    .wr_data_src(wr_data_src),
    .rd_data_src(f_rd_data_src),
    .tx_done_src(f_tx_done_src),
    .rd_valid_src(f_rd_valid_src),
    .op(f_op), .raw_address(f_raw_address),
    .wr_data(f_wr_data), .rd_data(rd_data),
    .tx_done(tx_done), .rd_valid(rd_valid),
    .busy(f_busy), .grant_id(f_grant_id),
    .proto_err(f_proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op_src = '0;
    raw_address_src = '0;
    address_offset_src = '0;
    wr_data_src = '0;
    rd_data = '0;
    tx_done = 1'b0;
    rd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (op !== 2'b00)
      $display("FAIL rst_op got %h want 0", op);
    else passed++;
    total++;
    if (busy !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL rst_busy_gid got %b/%0d want 0/0",
               busy, grant_id);
    else passed++;
    total++;
    if (raw_address !== '0 || wr_data !== '0 ||
        rd_data_src !== '0)
      $display("FAIL rst_data got %h want 0", raw_address);
    else passed++;
    total++;
    if (tx_done_src !== '0 || rd_valid_src !== '0 ||
        proto_err !== 1'b0)
      $display("FAIL rst_pulses got %b/%b/%b want 0",
               tx_done_src, rd_valid_src, proto_err);
    else passed++;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] a5;
    a5 = {64{8'hA5}};
    do_reset();
    op_src[2] = 2'b01;
    raw_address_src[2] = 64'h100;
    address_offset_src[2] = 64'h1000;
    tick();
    total++;
    if (op !== 2'b01 || raw_address !== 64'h1100)
      $display("FAIL rd_issue got op=%h addr=%h want 1/1100",
               op, raw_address);
    else passed++;
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd2)
      $display("FAIL rd_grant got %b/%0d want 1/2",
               busy, grant_id);
    else passed++;
    rd_valid = 1'b1;
    rd_data = a5;
    tick();
    rd_valid = 1'b0;
    rd_data = '0;
    total++;
    if (rd_valid_src !== 4'b0100 || rd_data_src !== a5)
      $display("FAIL rd_data got vld=%b d=%h want 0100/a5",
               rd_valid_src, rd_data_src[31:0]);
    else passed++;
    tick();
    total++;
    if (rd_valid_src !== 4'b0000 || tx_done_src !== 4'b0000)
      $display("FAIL rd_quiet got %b/%b want 0/0",
               rd_valid_src, tx_done_src);
    else passed++;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++;
    if (tx_done_src !== 4'b0100 || op !== 2'b00 ||
        busy !== 1'b0)
      $display("FAIL rd_done got %b op=%h b=%b want 0100/0/0",
               tx_done_src, op, busy);
    else passed++;
    op_src[2] = 2'b00;
    tick();
    total++;
    if (tx_done_src !== 4'b0000 || busy !== 1'b0)
      $display("FAIL rd_done_once got %b/%b want 0/0",
               tx_done_src, busy);
    else passed++;
    tick();
    total++;
    if (op !== 2'b00 || busy !== 1'b0)
      $display("FAIL rd_no_regrant got %h/%b want 0/0", op, busy);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5];
    logic [DW-1:0] exp_d;
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_src[i] = 2'b10;
      wr_data_src[i] = {64{8'(8'h10 + i)}};
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      exp_d = {64{8'(8'h10 + int'(exp_g[t]))}};
      total++;
      if (grant_id !== exp_g[t] || op !== 2'b10)
        $display("FAIL rr_grant%0d got %0d op=%h want %0d/2",
                 t, grant_id, op, exp_g[t]);
      else passed++;
      total++;
      if (wr_data !== exp_d)
        $display("FAIL rr_wdata%0d got %h want %h",
                 t, wr_data[31:0], exp_d[31:0]);
      else passed++;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      total++;
      if (tx_done_src !== (4'b0001 << exp_g[t]))
        $display("FAIL rr_done%0d got %b", t, tx_done_src);
      else passed++;
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    op_src[1] = 2'b01;
    op_src[3] = 2'b01;
    for (int t = 0; t < 3; t++) begin
      tick();
      total++;
      if (f_grant_id !== 2'd1 || f_busy !== 1'b1)
        $display("FAIL fx_grant%0d got %0d/%b want 1/1",
                 t, f_grant_id, f_busy);
      else passed++;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      total++;
      if (f_tx_done_src !== 4'b0010)
        $display("FAIL fx_done%0d got %b want 0010",
                 t, f_tx_done_src);
      else passed++;
      if (t == 2) op_src[1] = 2'b00;
      tick();
    end
    tick();
    total++;
    if (f_grant_id !== 2'd3)
      $display("FAIL fx_src3 got %0d want 3", f_grant_id);
    else passed++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_addr_wrap();
    do_reset();
    op_src[0] = 2'b01;
    raw_address_src[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    address_offset_src[0] = 64'h20;
    tick();
    total++;
    if (raw_address !== 64'h10)
      $display("FAIL wrap got %h want 10", raw_address);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    op_src[1] = 2'b01;
    raw_address_src[1] = 64'h40;
    tick();
    total++;
    if (grant_id !== 2'd1 || busy !== 1'b1)
      $display("FAIL mid_pre got %0d/%b want 1/1", grant_id, busy);
    else passed++;
    op_src[3] = 2'b01;
    rst_n = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total++;
    if (op !== 2'b00 || busy !== 1'b0 || grant_id !== 2'd0 ||
        raw_address !== '0 || tx_done_src !== '0)
      $display("FAIL mid_rst got op=%h b=%b g=%0d d=%b",
               op, busy, grant_id, tx_done_src);
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if (grant_id !== 2'd1 || busy !== 1'b1 ||
        tx_done_src !== '0)
      $display("FAIL mid_regrant got %0d/%b/%b want 1/1/0",
               grant_id, busy, tx_done_src);
    else passed++;
  endtask

  task automatic test_illegal_stray();
    do_reset();
    op_src[0] = 2'b11;
    tick();
    total++;
    if (proto_err !== 1'b1 || busy !== 1'b0 || op !== 2'b00)
      $display("FAIL ill_pulse got %b/%b/%h want 1/0/0",
               proto_err, busy, op);
    else passed++;
    op_src[0] = 2'b00;
    tick();
    total++;
    if (proto_err !== 1'b0)
      $display("FAIL ill_clear got %b want 0", proto_err);
    else passed++;
    tx_done = 1'b1;
    rd_valid = 1'b1;
    tick();
    tx_done = 1'b0;
    rd_valid = 1'b0;
    total++;
    if (tx_done_src !== '0 || rd_valid_src !== '0 ||
        busy !== 1'b0)
      $display("FAIL stray got %b/%b/%b want 0/0/0",
               tx_done_src, rd_valid_src, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_addr_wrap();
    test_reset_mid_op();
    test_illegal_stray();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
